// File: rtl/display_scan_driver.sv
// display_scan_driver
// Converts a captured 14-bit binary value (clamped to 9999) into four BCD
// digits with a sequential double-dabble FSM. It also scans those digits
// onto a 4-position multiplexed display with active-low anodes.
// The displayed digits/flag update only when a conversion has fully finished.
// Optional build macro: LEADING_ZERO_BLANK_EN turns off the anodes of leading
// zero positions. The units digit stays lit.
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [13:0] value,
  input  logic [2:0]  flag_in,
  output logic [3:0]  digit,
  output logic [2:0]  idx,
  output logic [2:0]  flag,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int              CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(REFRESH_DIV - 1);
  localparam logic [13:0]     MAX_VALUE = 14'd9999;
  localparam logic [3:0]      LAST_ITER = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // Conversion state
  state_t           r_state;
  logic [29:0]      r_sr;        // {bcd[15:0], binary[13:0]} working register
  logic [3:0]       r_iter;
  logic [2:0]       r_flag_cap;
  logic             r_busy;

  // Displayed register set
  logic [15:0]      r_bcd;
  logic [2:0]       r_flag;

  // Scan state
  logic [CNT_W-1:0] r_refresh;
  logic [1:0]       r_idx;
  logic [3:0]       r_digit;
  logic [3:0]       r_an;

  logic [13:0]      w_value_clamped;
  logic             w_refresh_wrap;
  logic [1:0]       w_idx_next;
  logic [15:0]      w_bcd_next;
  logic [3:0]       w_lit_mask;
  logic [3:0]       w_digit_next;
  logic [3:0]       w_an_next;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
  function automatic logic [29:0] dd_step(input logic [29:0] sr);
    logic [29:0] t;
    // NOTE: blocking assignments are correct here; t is a local temporary
    // inside a function, not clocked state.
    t = sr;
    for (int k = 0; k < 4; k++) begin
      if (t[14 + 4*k +: 4] >= 4'd5) t[14 + 4*k +: 4] = t[14 + 4*k +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  assign w_value_clamped = (value > MAX_VALUE) ? MAX_VALUE : value;

  // Conversion FSM: capture on an idle load, 14 shift cycles, then publish
  // the result in a single DONE cycle.
  always_ff @(posedge clk) begin
    // NOTE: every register in a clocked block uses non-blocking assignments so
    // all of them update together from values sampled at the same edge.
    if (reset) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_iter     <= '0;
      r_flag_cap <= '0;
      r_busy     <= 1'b0;
      r_bcd      <= '0;
      r_flag     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_sr       <= {16'd0, w_value_clamped};
            r_flag_cap <= flag_in;
            r_iter     <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sr <= dd_step(r_sr);
          if (r_iter == LAST_ITER) r_state <= S_DONE;
          else                     r_iter  <= r_iter + 4'd1;
        end
        S_DONE: begin
          r_bcd   <= r_sr[29:14];
          r_flag  <= r_flag_cap;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The scan block looks one edge ahead so that digit/an move together with
  // idx and with a freshly published BCD value.
  assign w_refresh_wrap = (r_refresh == CNT_TERM);
  assign w_idx_next     = w_refresh_wrap ? r_idx + 2'd1 : r_idx;
  assign w_bcd_next     = (r_state == S_DONE) ? r_sr[29:14] : r_bcd;

`ifdef LEADING_ZERO_BLANK_EN
  // A position is lit if it or any higher position holds a nonzero digit.
  assign w_lit_mask[3] = |w_bcd_next[15:12];
  assign w_lit_mask[2] = w_lit_mask[3] | (|w_bcd_next[11:8]);
  assign w_lit_mask[1] = w_lit_mask[2] | (|w_bcd_next[7:4]);
  assign w_lit_mask[0] = 1'b1;
`else
  assign w_lit_mask = 4'b1111;
`endif

  assign w_digit_next = w_bcd_next[4*w_idx_next +: 4];
  assign w_an_next    = ~(4'b0001 << w_idx_next) | ~w_lit_mask;

  // Free-running refresh counter and digit rotation, independent of conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
      r_digit   <= '0;
      r_an      <= 4'b1110;
    end else begin
      r_refresh <= w_refresh_wrap ? '0 : r_refresh + CNT_W'(1);
      r_idx     <= w_idx_next;
      r_digit   <= w_digit_next;
      r_an      <= w_an_next;
    end
  end

  assign digit = r_digit;
  assign idx   = {1'b0, r_idx};
  assign flag  = r_flag;
  assign an    = r_an;
  assign busy  = r_busy;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with REFRESH_DIV = 4.
// Build with LEADING_ZERO_BLANK_EN defined to check the blanking variant.
module tb_display_scan_driver;

  localparam int RDIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [13:0] value;
  logic [2:0]  flag_in;
  logic [3:0]  digit;
  logic [2:0]  idx;
  logic [2:0]  flag;
  logic [3:0]  an;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;        // edges since the last edge that saw reset high

  logic [15:0] m_bcd;   // expected displayed BCD
  logic [2:0]  m_flag;  // expected displayed flag

  display_scan_driver #(.REFRESH_DIV(RDIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .value   (value),
    .flag_in (flag_in),
    .digit   (digit),
    .idx     (idx),
    .flag    (flag),
    .an      (an),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_an(input int i, input logic [15:0] b);
    logic [3:0]  a;
    logic [15:0] hi;
    a  = ~(4'b0001 << i);
    hi = b >> (4 * i);
    if (BLANK && i != 0 && hi == 16'd0) a = 4'b1111;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset) cyc = 0;
      else       cyc++;
      #1;
    end
  endtask

  task automatic chk_scan(input string tag, input logic exp_busy);
    int          i;
    logic [15:0] sh;
    i  = (cyc / RDIV) % 4;
    sh = m_bcd >> (4 * i);
    chk({tag, "/idx"},   32'(idx),   32'(i));
    chk({tag, "/an"},    32'(an),    32'(exp_an(i, m_bcd)));
    chk({tag, "/digit"}, 32'(digit), 32'(sh[3:0]));
    chk({tag, "/flag"},  32'(flag),  32'(m_flag));
    chk({tag, "/busy"},  32'(busy),  32'(exp_busy));
  endtask

  task automatic run_scan(input string tag, input int n, input logic exp_busy);
    for (int k = 0; k < n; k++) begin
      chk_scan(tag, exp_busy);
      step(1);
    end
  endtask

  task automatic do_load(input logic [13:0] v, input logic [2:0] f);
    value   = v;
    flag_in = f;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
  endtask

  // Load v/f, check 15 busy cycles showing the old display, then the new one.
  // If intrude_at >= 0, a second load is attempted that many cycles in.
  task automatic conv(input string tag, input logic [13:0] v, input logic [2:0] f,
                      input logic [15:0] exp_bcd, input logic [2:0] exp_flag,
                      input int intrude_at, input logic [13:0] intrude_v);
    do_load(v, f);
    for (int k = 0; k < 15; k++) begin
      chk_scan({tag, "_busy"}, 1'b1);
      if (k == intrude_at) begin
        value = intrude_v;
        load  = 1'b1;
      end
      step(1);
      load = 1'b0;
    end
    m_bcd  = exp_bcd;
    m_flag = exp_flag;
    run_scan({tag, "_shown"}, 16, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    value   = '0;
    flag_in = '0;
    m_bcd   = '0;
    m_flag  = '0;
    step(2);
    reset = 1'b0;

    // Reset state followed by one idle scan rotation.
    run_scan("idle", 16, 1'b0);

    conv("ld1234",  14'd1234,  3'd0, 16'h1234, 3'd0, -1, 14'd0);
    conv("clamp",   14'd12000, 3'd5, 16'h9999, 3'd5, -1, 14'd0);
    conv("max9999", 14'd9999,  3'd7, 16'h9999, 3'd7, -1, 14'd0);
    conv("ld42",    14'd42,    3'd1, 16'h0042, 3'd1,  4, 14'd77);

    // Reset during a conversion: aborted, display zero, no late update.
    do_load(14'd5678, 3'd3);
    for (int k = 0; k < 8; k++) begin
      chk_scan("abort_busy", 1'b1);
      if (k == 7) reset = 1'b1;
      step(1);
    end
    reset  = 1'b0;
    m_bcd  = '0;
    m_flag = '0;
    run_scan("abort_after", 24, 1'b0);

    conv("zero", 14'd0, 3'd2, 16'h0000, 3'd2, -1, 14'd0);

    // Load coincident with reset is ignored.
    reset   = 1'b1;
    load    = 1'b1;
    value   = 14'd1111;
    flag_in = 3'd6;
    step(1);
    reset  = 1'b0;
    load   = 1'b0;
    m_bcd  = '0;
    m_flag = '0;
    run_scan("ld_rst", 20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
